// File: rtl/gpio_in_pkg.sv
// Shared constants and counter-width helper for the switch-input debounce block.
package gpio_in_pkg;

  localparam int GPIO_IN_WIDTH           = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Width able to hold 0..cycles; clamp so a degenerate value still yields one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_in_debounce_bit.sv
// One switch bit: 2-flop synchroniser, mismatch counter, debounced level and edge strobes.
module debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_next_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sw_q, sw_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw_i;
    sync2_d = sync1_q;
    sw_d    = sw_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any cycle of agreement restarts the count, so only an unbroken run flips the output.
    if (sync2_q != sw_q) begin
      if (cnt_q == CNT_MAX) begin
        sw_d   = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o        = sw_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign edge_next_o = rise_d | fall_d;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced GPIO input conditioning; sticky change interrupt built only with
// GPIO_IN_DEBOUNCE_IRQ_EN defined.
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = GPIO_IN_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] irq_pending_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] edge_next;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_i       (sw_i[i]),
      .sw_o       (sw_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .edge_next_o(edge_next[i])
    );
  end

  // Built from the strobes' next state so it lands in the same cycle as rise_o/fall_o.
  always_comb begin
    changed_d = |edge_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) changed_q <= 1'b0;
    else          changed_q <= changed_d;
  end

  assign changed_o = changed_q;

`ifdef GPIO_IN_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             irq_q, irq_d;

  // A new strobe outranks a clear arriving in the same cycle.
  always_comb begin
    pending_d = (rise_o | fall_o) | (pending_q & ~irq_clr_i);
    irq_d     = |pending_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_pending_o = pending_q;
  assign irq_o         = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = ^irq_clr_i;
  assign irq_pending_o  = '0;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Conditions raw board switch inputs before they reach the SoC GPIO input half (`io_data[31:16]`).
- Per bit, it performs:
  - 2-flop synchronisation into the core clock domain (the divided-by-2 core clock).
  - Counter-based debounce.
  - Single-cycle rise/fall strobes.
- Sits in the FPGA top, between the switch pins and the `rv32i_soc` instance.
- Optionally raises a sticky change interrupt.

Parameters:
- `WIDTH`, 16, number of input bits conditioned.
- `DEBOUNCE_CYCLES`, 500000, consecutive core-clock cycles a synchronised input must differ from the debounced value before the output flips. Must be ≥1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`, derived counter width. Not overridden by users.

Ports:
- `clk` input 1: core clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `sw_i` input `WIDTH`: raw asynchronous switch levels.
- `sw_o` output `WIDTH`: debounced levels, feeds GPIO input bits.
- `rise_o` output `WIDTH`: one-cycle pulse when the corresponding `sw_o` bit goes 0→1.
- `fall_o` output `WIDTH`: one-cycle pulse when the corresponding `sw_o` bit goes 1→0.
- `changed_o` output 1: OR of `rise_o | fall_o`, registered with them.
- `irq_clr_i` input `WIDTH`: write-1-to-clear for pending bits (only used with the optional feature).
- `irq_pending_o` output `WIDTH`: sticky change flags.
- `irq_o` output 1: OR-reduce of `irq_pending_o`.

Behaviour:
- **Reset:** all state is cleared on the first rising `clk` edge with `reset_n`=0, and held there while low. This covers sync flops, counters, `sw_o`, `rise_o`, `fall_o`, `changed_o`, `irq_pending_o` and `irq_o`, all to 0.
- **Reset mid-operation:** any partially accumulated debounce count is discarded. After release, a switch that is high re-debounces from 0 and produces a `rise_o` pulse.
- **Synchroniser:** `sync1 <= sw_i; sync2 <= sync1`. No logic between the two flops.
- **Per-bit debounce counter `cnt[i]`:**
  - If `sync2[i] == sw_o[i]`: `cnt[i] <= 0`. Any glitch shorter than `DEBOUNCE_CYCLES` restarts the count.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_o[i] <= sync2[i]`, `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- **Latency:** a clean step on `sw_i` set up before edge 0 appears on `sw_o` after edge `DEBOUNCE_CYCLES+1`, i.e. `DEBOUNCE_CYCLES+2` edges total.
  - `DEBOUNCE_CYCLES`=1 degenerates to a pure 2-flop sync plus one register: flip on the first mismatch cycle.
- **Strobes:**
  - `rise_o[i]` and `fall_o[i]` are registered and asserted in the same cycle `sw_o[i]` shows its new value, for exactly one cycle.
  - `changed_o` follows the same timing.
  - Bits are fully independent; several bits may strobe in the same cycle.
- **Stable input:** no strobes are produced and counters sit at 0.

Optional Feature:
- Macro: `GPIO_IN_DEBOUNCE_IRQ_EN`.
- **Defined:**
  - Priority: `irq_pending_o[i]` sets on `rise_o[i] | fall_o[i]` in the cycle after the strobe. Otherwise it clears when `irq_clr_i[i]`=1. Otherwise it holds.
  - Simultaneous set and clear on the same bit leaves it set; set wins.
  - `irq_o` is registered as the OR of next-state pending bits, so it is coincident with `irq_pending_o`.
- **Undefined:**
  - `irq_pending_o` and `irq_o` are tied to 0.
  - `irq_clr_i` is ignored.
  - No pending flops are synthesised; ports remain for a stable interface.

Decomposition:
- Package `gpio_in_pkg`: `DEBOUNCE_CYCLES_DEFAULT`, `GPIO_IN_WIDTH` (16) and a helper function for the counter width.
- Natural sub-module `debounce_bit`: one bit of synchroniser, counter, `sw_o` and edge strobes, parameterised by `DEBOUNCE_CYCLES`.
  - Top instantiates `WIDTH` copies in a generate loop and adds `changed_o` and the optional IRQ logic.

Test Plan (`DEBOUNCE_CYCLES`=4, `WIDTH`=16 unless stated):
1. Reset:
   - Stimulus: hold `reset_n`=0 for 3 edges with `sw_i`=16'hFFFF, then release.
   - Response: all outputs 0 during reset. `sw_o`=16'hFFFF 6 edges after release, with `rise_o`=16'hFFFF for exactly one cycle.
2. Clean step:
   - Stimulus: `sw_i[3]` 0→1 before edge 0.
   - Response: `sw_o[3]`=1 from edge 5 on (6 edges). `rise_o`=16'h0008 and `changed_o`=1 for one cycle only. Then step 1→0 gives `fall_o`=16'h0008 with the same timing.
3. Glitch rejection:
   - Stimulus: `sw_i[0]` high for 3 cycles, low, then high for 3 cycles.
   - Response: `sw_o[0]` stays 0 and no strobes. Follow with a 4-cycle high pulse: `sw_o[0]` goes 1.
4. Simultaneous multi-bit:
   - Stimulus: `sw_i` 0→16'hA5A5 in one cycle.
   - Response: `sw_o`=16'hA5A5 and `rise_o`=16'hA5A5 in the same single cycle.
5. IRQ (macro defined):
   - Stimulus: step bit 7.
   - Response: `irq_pending_o`=16'h0080 and `irq_o`=1, held. Pulse `irq_clr_i`=16'h0080: both return to 0 next cycle. Clear coinciding with a new strobe on bit 7 leaves it set.
6. Reset mid-debounce:
   - Stimulus: assert `reset_n`=0 after 2 mismatch cycles on bit 1.
   - Response: counter and outputs return to 0. After release, bit 1 requires a full 6 edges again.
